// File: rtl/cdr_ctrl_pkg.sv
// Shared types and widths for the CDR lock sequencer.
package cdr_ctrl_pkg;

   localparam int unsigned TIMER_W = 16;
   localparam int unsigned RETRY_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RESET   = 3'd1,
      ST_ACQUIRE = 3'd2,
      ST_LOCKED  = 3'd3,
      ST_BACKOFF = 3'd4,
      ST_FAIL    = 3'd5
   } state_e;

endpackage

// File: rtl/cdr_lock_ctrl.sv
// CDR bring-up sequencer: reset hold, timed acquisition with bounded retries,
// filtered lock-loss detection and qualified lock/valid reporting.
module cdr_lock_ctrl
   import cdr_ctrl_pkg::*;
#(
   parameter int unsigned RST_HOLD_CYC    = 4,
   parameter int unsigned ACQ_TIMEOUT_CYC = 1024,
   parameter int unsigned LOSS_FILTER_CYC = 8,
   parameter int unsigned BACKOFF_CYC     = 16,
   parameter int unsigned MAX_RETRIES     = 3
) (
   input  logic               i_clk_ref,
   input  logic               i_rst_n,
   input  logic               i_enable,
   input  logic               i_hs_mode_req,
   input  logic               i_cdr_lock,
   input  logic               i_cdr_data_valid,
   input  logic               i_clear_fail,
   output logic               o_cdr_rst_n,
   output logic               o_cdr_hs_mode,
   output logic               o_locked,
   output logic               o_rx_valid,
   output logic               o_fail,
   output logic [RETRY_W-1:0] o_retry_cnt,
   output logic [2:0]         o_state
);

   // Timer value on the last cycle of each timed interval
   localparam logic [TIMER_W-1:0] RST_LAST  = TIMER_W'(RST_HOLD_CYC - 1);
   localparam logic [TIMER_W-1:0] ACQ_LAST  = TIMER_W'(ACQ_TIMEOUT_CYC - 1);
   localparam logic [TIMER_W-1:0] LOSS_LAST = TIMER_W'(LOSS_FILTER_CYC - 1);
   localparam logic [TIMER_W-1:0] BKO_LAST  = TIMER_W'(BACKOFF_CYC - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic                 hs_mode_q, hs_mode_d;
   logic                 cdr_rst_n_q, cdr_rst_n_d;
   logic                 locked_q, locked_d;
   logic                 fail_q, fail_d;
   logic                 timer_clr;
   logic                 mode_chg;

   always_ff @(posedge i_clk_ref or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         retry_q     <= '0;
         hs_mode_q   <= 1'b0;
         cdr_rst_n_q <= 1'b0;
         locked_q    <= 1'b0;
         fail_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         retry_q     <= retry_d;
         hs_mode_q   <= hs_mode_d;
         cdr_rst_n_q <= cdr_rst_n_d;
         locked_q    <= locked_d;
         fail_q      <= fail_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      retry_d   = retry_q;
      hs_mode_d = hs_mode_q;
      timer_clr = 1'b0;
      mode_chg  = (i_hs_mode_req != hs_mode_q) &&
                  (state_q inside {ST_RESET, ST_ACQUIRE, ST_LOCKED, ST_BACKOFF});

      if (!i_enable) begin
         state_d = ST_IDLE;
      end else if (mode_chg) begin
         state_d   = ST_RESET;
         hs_mode_d = i_hs_mode_req;
         retry_d   = '0;
         timer_clr = 1'b1;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               state_d   = ST_RESET;
               hs_mode_d = i_hs_mode_req;
               retry_d   = '0;
            end
            ST_RESET: begin
               if (timer_q == RST_LAST) state_d = ST_ACQUIRE;
            end
            ST_ACQUIRE: begin
               // Lock has priority over a coincident timeout
               if (i_cdr_lock) begin
                  state_d = ST_LOCKED;
               end else if (timer_q == ACQ_LAST) begin
                  if (retry_q == RETRY_MAX) begin
                     state_d = ST_FAIL;
                  end else begin
                     state_d = ST_BACKOFF;
                     retry_d = retry_q + RETRY_W'(1);
                  end
               end
            end
            ST_LOCKED: begin
               // Timer doubles as the consecutive-lock-low counter here
               if (i_cdr_lock) begin
                  timer_clr = 1'b1;
               end else if (timer_q == LOSS_LAST) begin
                  state_d = ST_RESET;
                  retry_d = '0;
               end
            end
            ST_BACKOFF: begin
               if (timer_q == BKO_LAST) state_d = ST_ACQUIRE;
            end
            ST_FAIL: begin
               if (i_clear_fail) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end

      if (timer_clr || (state_d != state_q)) begin
         timer_d = '0;
      end else if (timer_q == '1) begin
         timer_d = timer_q;
      end else begin
         timer_d = timer_q + TIMER_W'(1);
      end

      cdr_rst_n_d = (state_d == ST_ACQUIRE) || (state_d == ST_LOCKED);
      locked_d    = (state_d == ST_LOCKED);
      fail_d      = (state_d == ST_FAIL);
   end

   assign o_cdr_rst_n   = cdr_rst_n_q;
   assign o_cdr_hs_mode = hs_mode_q;
   assign o_locked      = locked_q;
   assign o_rx_valid    = locked_q & i_cdr_data_valid;
   assign o_fail        = fail_q;
   assign o_retry_cnt   = retry_q;
   assign o_state       = state_q;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Directed bench for cdr_lock_ctrl: vector table for bring-up and retry
// exhaustion, plus hand-written multi-cycle corner sequences.
module tb_cdr_lock_ctrl;

   localparam logic [2:0] S_IDLE = 3'd0, S_RST = 3'd1, S_ACQ = 3'd2,
                          S_LCK  = 3'd3, S_BKO = 3'd4, S_FAIL = 3'd5;
   localparam int B = 24;

   logic       clk;
   logic       rst_n, en, hs, lock, dv, clr;
   logic       cdr_rst_n, cdr_hs, locked, rx_valid, fail;
   logic [3:0] retry;
   logic [2:0] state;

   int total = 0;
   int bad   = 0;
   int cyc   = -1;

   cdr_lock_ctrl #(
      .RST_HOLD_CYC(4), .ACQ_TIMEOUT_CYC(64), .LOSS_FILTER_CYC(8),
      .BACKOFF_CYC(16), .MAX_RETRIES(2)
   ) dut (
      .i_clk_ref(clk), .i_rst_n(rst_n), .i_enable(en), .i_hs_mode_req(hs),
      .i_cdr_lock(lock), .i_cdr_data_valid(dv), .i_clear_fail(clr),
      .o_cdr_rst_n(cdr_rst_n), .o_cdr_hs_mode(cdr_hs), .o_locked(locked),
      .o_rx_valid(rx_valid), .o_fail(fail), .o_retry_cnt(retry), .o_state(state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         at;
      logic       en, hs, lock, dv, clr;
      logic [2:0] st;
      logic       rstn, hsm, lk, rxv, fl;
      logic [3:0] rc;
   } vec_t;

   vec_t vecs[23];

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic ticks(input int n);
      repeat (n) tick();
   endtask

   task automatic chk(input string nm, input logic [2:0] st, input logic rstn,
                      input logic hsm, input logic lk, input logic rxv,
                      input logic fl, input logic [3:0] rc);
      total++;
      if ({state, cdr_rst_n, cdr_hs, locked, rx_valid, fail, retry} !==
          {st, rstn, hsm, lk, rxv, fl, rc}) begin
         bad++;
         $display("FAIL %s cyc=%0d got st=%0d rstn=%b hs=%b lk=%b rxv=%b fail=%b rc=%0d exp st=%0d rstn=%b hs=%b lk=%b rxv=%b fail=%b rc=%0d",
                  nm, cyc, state, cdr_rst_n, cdr_hs, locked, rx_valid, fail, retry,
                  st, rstn, hsm, lk, rxv, fl, rc);
      end
   endtask

   // From any state: drop enable, re-enable, lock on first ACQUIRE cycle
   task automatic bring_locked(input logic hs_v);
      en = 1'b0; lock = 1'b0; dv = 1'b0; clr = 1'b0;
      tick();
      en = 1'b1; hs = hs_v;
      ticks(5);
      lock = 1'b1;
      tick();
      chk("bring_locked", S_LCK, 1'b1, hs_v, 1'b1, 1'b0, 1'b0, 4'd0);
   endtask

   initial begin
      //          at      en hs lk dv cl  st      rstn hsm lk rxv fl rc
      vecs[0]  = '{0,      1, 1, 0, 1, 0, S_IDLE, 0,   0,  0, 0,  0, 0};
      vecs[1]  = '{1,      1, 1, 0, 1, 0, S_RST,  0,   1,  0, 0,  0, 0};
      vecs[2]  = '{4,      1, 1, 0, 1, 0, S_RST,  0,   1,  0, 0,  0, 0};
      vecs[3]  = '{5,      1, 1, 0, 1, 0, S_ACQ,  1,   1,  0, 0,  0, 0};
      vecs[4]  = '{20,     1, 1, 1, 1, 0, S_ACQ,  1,   1,  0, 0,  0, 0};
      vecs[5]  = '{21,     1, 1, 1, 0, 0, S_LCK,  1,   1,  1, 1,  0, 0};
      vecs[6]  = '{22,     1, 1, 1, 1, 0, S_LCK,  1,   1,  1, 0,  0, 0};
      vecs[7]  = '{23,     0, 1, 1, 1, 0, S_LCK,  1,   1,  1, 1,  0, 0};
      vecs[8]  = '{B,      1, 0, 0, 0, 0, S_IDLE, 0,   1,  0, 0,  0, 0};
      vecs[9]  = '{B+1,    1, 0, 0, 0, 0, S_RST,  0,   0,  0, 0,  0, 0};
      vecs[10] = '{B+5,    1, 0, 0, 0, 0, S_ACQ,  1,   0,  0, 0,  0, 0};
      vecs[11] = '{B+68,   1, 0, 0, 0, 0, S_ACQ,  1,   0,  0, 0,  0, 0};
      vecs[12] = '{B+69,   1, 0, 0, 0, 0, S_BKO,  0,   0,  0, 0,  0, 1};
      vecs[13] = '{B+84,   1, 0, 0, 0, 0, S_BKO,  0,   0,  0, 0,  0, 1};
      vecs[14] = '{B+85,   1, 0, 0, 0, 0, S_ACQ,  1,   0,  0, 0,  0, 1};
      vecs[15] = '{B+148,  1, 0, 0, 0, 0, S_ACQ,  1,   0,  0, 0,  0, 1};
      vecs[16] = '{B+149,  1, 0, 0, 0, 0, S_BKO,  0,   0,  0, 0,  0, 2};
      vecs[17] = '{B+165,  1, 0, 0, 0, 0, S_ACQ,  1,   0,  0, 0,  0, 2};
      vecs[18] = '{B+228,  1, 0, 0, 0, 0, S_ACQ,  1,   0,  0, 0,  0, 2};
      vecs[19] = '{B+229,  1, 1, 0, 0, 0, S_FAIL, 0,   0,  0, 0,  1, 2};
      vecs[20] = '{B+230,  1, 1, 0, 0, 1, S_FAIL, 0,   0,  0, 0,  1, 2};
      vecs[21] = '{B+231,  1, 1, 0, 0, 0, S_IDLE, 0,   0,  0, 0,  0, 2};
      vecs[22] = '{B+232,  1, 1, 0, 0, 0, S_RST,  0,   1,  0, 0,  0, 0};

      rst_n = 1'b0; en = 1'b0; hs = 1'b0; lock = 1'b0; dv = 1'b1; clr = 1'b0;
      #2;
      chk("reset_state", S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      dv = 1'b0;
      #20 rst_n = 1'b1;
      tick();

      // Bring-up, data-valid gating, disable, then retry exhaustion to FAIL
      for (int i = 0; i < 23; i++) begin
         while (cyc < vecs[i].at) tick();
         chk($sformatf("vec%0d", i), vecs[i].st, vecs[i].rstn, vecs[i].hsm,
             vecs[i].lk, vecs[i].rxv, vecs[i].fl, vecs[i].rc);
         en = vecs[i].en; hs = vecs[i].hs; lock = vecs[i].lock;
         dv = vecs[i].dv; clr = vecs[i].clr;
      end

      // Lock after one failed attempt, then loss-filter glitch handling
      en = 1'b0; lock = 1'b0; clr = 1'b0; dv = 1'b0;
      tick();
      en = 1'b1; hs = 1'b1;
      ticks(5);
      chk("gl_acq", S_ACQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      ticks(64);
      chk("gl_backoff", S_BKO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      ticks(16);
      chk("gl_reacq", S_ACQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      lock = 1'b1;
      tick();
      chk("gl_locked", S_LCK, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      lock = 1'b0;
      ticks(7);
      chk("gl_low7", S_LCK, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      lock = 1'b1;
      tick();
      chk("gl_relock", S_LCK, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      lock = 1'b0;
      ticks(7);
      chk("gl_low8_pre", S_LCK, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd1);
      tick();
      chk("gl_loss", S_RST, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);

      // Mode change while LOCKED
      bring_locked(1'b1);
      hs = 1'b0;
      tick();
      chk("mc_reset", S_RST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      ticks(3);
      chk("mc_hold", S_RST, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      tick();
      chk("mc_acq", S_ACQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

      // Lock coincident with timeout, then disable coincident with mode change
      en = 1'b0; lock = 1'b0;
      tick();
      en = 1'b1; hs = 1'b0;
      ticks(68);
      chk("sim_last_acq", S_ACQ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      lock = 1'b1;
      tick();
      chk("sim_lock_wins", S_LCK, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0);
      en = 1'b0; hs = 1'b1;
      tick();
      chk("sim_dis_wins", S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

      // Asynchronous reset in BACKOFF, then a fresh bring-up
      lock = 1'b0; dv = 1'b1;
      tick();
      en = 1'b1; hs = 1'b1;
      ticks(69);
      chk("ar_backoff", S_BKO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd1);
      ticks(3);
      #3 rst_n = 1'b0;
      #1;
      chk("ar_async", S_IDLE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
      #2 rst_n = 1'b1;
      tick();
      chk("ar_reset", S_RST, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      ticks(4);
      chk("ar_acq", S_ACQ, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
      lock = 1'b1;
      tick();
      chk("ar_locked", S_LCK, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
